writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
//
// Small FIFO that buffers results on their way to a register file write port.
// The register file's read cycles normally take priority over draining the
// queue. If the queue stays full and blocked for MAX_STALL cycles, one write is
// forced through. A lookup port lets younger instructions bypass results that
// have not yet reached the register file.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   producer handshake; push when both are high
//   in_addr, in_data    destination register and value of the offered result
//   rd_req, rd_grant    register-file read request; granted when no write
//   we, Rw, din         register-file write port (head of the queue)
//   hit_addr            bypass lookup address
//   hit, hit_data       youngest queued value for hit_addr (0 when no hit)
//   count               number of valid entries
// -----------------------------------------------------------------------------
module writeback_queue #(
    parameter int DEPTH     = 4,
    parameter int DW        = 64,
    parameter int AW        = 5,
    parameter int MAX_STALL = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     rd_req,
    output logic                     rd_grant,
    output logic                     we,
    output logic [AW-1:0]            Rw,
    output logic [DW-1:0]            din,
    input  logic [AW-1:0]            hit_addr,
    output logic                     hit,
    output logic [DW-1:0]            hit_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [SW-1:0] stall_reg, stall_next;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];

    logic full;
    logic not_empty;
    logic force_wr;
    logic push;
    logic pop;

    // Occupancy flags come from registered state only, so a full queue never
    // accepts in the same cycle it pops.
    assign full      = (count_reg == CW'(DEPTH));
    assign not_empty = (count_reg != '0);
    assign force_wr  = (stall_reg == SW'(MAX_STALL));

    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign we        = not_empty && (!rd_req || force_wr);
    assign pop       = we;
    assign rd_grant  = rd_req && !we;

    assign Rw        = not_empty ? mem_addr[rd_ptr_reg] : '0;
    assign din       = not_empty ? mem_data[rd_ptr_reg] : '0;
    assign count     = count_reg;

    // Storage holds no reset: only count/pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_reg] <= in_addr;
            mem_data[wr_ptr_reg] <= in_data;
        end
    end

    // Pointers are PW bits wide and DEPTH is a power of two, so the increment
    // wraps from DEPTH-1 to 0 on its own.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Counts consecutive cycles where the queue is full and the read port
    // won. Reaching MAX_STALL forces one write, which clears it again.
    always_comb begin
        stall_next = stall_reg;
        if (we || !full) begin
            stall_next = '0;
        end else if (rd_req && !force_wr) begin
            stall_next = stall_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            stall_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            stall_reg  <= stall_next;
        end
    end

    // Bypass lookup, indexed by age: slot gi is the gi-th oldest entry. The
    // head being popped this cycle is still searched.
    logic [DEPTH-1:0] age_match;
    logic [DW-1:0]    age_data [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PW-1:0] idx;
            assign idx           = rd_ptr_reg + PW'(gi);
            assign age_match[gi] = (CW'(gi) < count_reg) && (mem_addr[idx] == hit_addr);
            assign age_data[gi]  = mem_data[idx];
        end
    endgenerate

    // Scan oldest to youngest so the youngest match overrides earlier ones.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_match[k]) begin
                hit      = 1'b1;
                hit_data = age_data[k];
            end
        end
    end

endmodule
